// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and defaults for the RAM port arbiter slice.
//   - arb_state_t : arbiter FSM state encoding (IDLE, ISSUE, WAIT_RD)
//   - ram_cmd_t   : latched command of the current owner (we, addr, wdata)
//   - DEF_ADDR_W / DEF_DATA_W : geometry of the 16x32 single-port RAM
//   - idx_width() : width of a requester index for a given requester count
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  // Field widths follow the RAM geometry above; the arbiter's ADDR_W/DATA_W
  // parameters default to these values and are expected to match them.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } ram_cmd_t;

  // A single requester still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin search. The winner is the first set request
//   bit found when searching upward from ptr+1, wrapping modulo NUM_REQ, so
//   the most recent owner (ptr) has the lowest priority.
// Ports
//   req           in   NUM_REQ  request vector
//   ptr           in   IDX_W    index of the most recent winner
//   winner_onehot out  NUM_REQ  one-hot winner (zero when no request)
//   winner_idx    out  IDX_W    binary index of the winner (zero when no request)
//   any           out  1        at least one request is pending
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  // Walk the candidates in priority order; the found flag freezes the first hit.
  always_comb begin
    int   cand;
    logic found;
    winner_onehot = '0;
    winner_idx    = '0;
    found         = 1'b0;
    cand          = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found               = 1'b1;
        winner_onehot[cand] = 1'b1;
        winner_idx          = IDX_W'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port 16x32 RAM between NUM_REQ requesters with
//   round-robin arbitration and a single command in flight.
//   Write occupancy is 2 cycles (IDLE, ISSUE); read occupancy is 3 cycles
//   (IDLE, ISSUE, WAIT_RD) with the response pulsed in the next IDLE.
// Ports
//   clk, rst              clock (posedge) and asynchronous active-low reset
//   req/we                per-requester request and write select
//   addr/wdata            per-requester packed address / write data, slice i = requester i
//   gnt                   one-cycle accept pulse, one-hot or zero
//   rsp_valid/rdata       one-cycle read response to the owner, with its data
//   mem_en/mem_write      RAM enable and write strobe (high only in ISSUE)
//   mem_address/mem_data  RAM address and write data, held between commands
//   mem_data_out          RAM read data
//   mem_valid_out         RAM read-valid flag
//   rd_err                sticky flag: RAM did not flag valid data on a read
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_valid_out,
  output logic                      rd_err
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t         state;
  ram_cmd_t           cmd;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req           (req),
    .ptr           (ptr),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx),
    .any           (win_any)
  );

  // The command latch doubles as the RAM address/data register, so these
  // pins hold their last value between commands without extra flops.
  assign mem_address = cmd.addr;
  assign mem_data    = cmd.wdata;

  // Arbiter FSM. ptr doubles as the owner index of the command in flight.
  // Pulses (gnt, rsp_valid, mem_en, mem_write) default low every cycle.
  // Arbitration in IDLE loads the pulse registers directly so that gnt and
  // mem_en are visible during the ISSUE cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      cmd       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_write <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      mem_en    <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            cmd.we    <= we[win_idx];
            cmd.addr  <= addr[win_idx*ADDR_W +: ADDR_W];
            cmd.wdata <= wdata[win_idx*DATA_W +: DATA_W];
            ptr       <= win_idx;
            gnt       <= win_onehot;
            mem_en    <= 1'b1;
            mem_write <= we[win_idx];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= cmd.we ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          rdata          <= mem_data_out;
          rsp_valid[ptr] <= 1'b1;
          if (!mem_valid_out) begin
            rd_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
